// File: rtl/cache_fill_if.sv
// Bus bundle between the miss-fill controller and its environment
// (hit/miss compare logic, main memory, data and metadata way arrays).
// master: the fill controller (drives fill/array controls).
// slave : the environment (drives miss request, metadata, memory return).
// Optional port critical_word_valid exists only with FILL_CRITICAL_WORD_FIRST_EN.
interface cache_fill_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned META_W = 8;
  localparam int unsigned WORDS  = 8;
  localparam int unsigned SETS   = 64;

  logic                miss_detected;
  logic [ADDR_W-1:0]   miss_address;
  logic [META_W-1:0]   way0_meta;
  logic [META_W-1:0]   way1_meta;
  logic [DATA_W-1:0]   memory_data;
  logic                memory_data_valid;
  logic                fsm_busy;
  logic                memory_enable;
  logic [ADDR_W-1:0]   memory_address;
  logic                write_data_array;
  logic                data_way_sel;
  logic [WORDS-1:0]    word_enable;
  logic [SETS-1:0]     set_enable;
  logic [DATA_W-1:0]   data_out;
  logic [1:0]          meta_wen;
  logic [META_W-1:0]   meta_way0_in;
  logic [META_W-1:0]   meta_way1_in;
  logic                fill_done;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
  logic                critical_word_valid;
`endif

  modport master (
    input  miss_detected, miss_address, way0_meta, way1_meta,
           memory_data, memory_data_valid,
    output fsm_busy, memory_enable, memory_address, write_data_array,
           data_way_sel, word_enable, set_enable, data_out, meta_wen,
           meta_way0_in, meta_way1_in,
`ifdef FILL_CRITICAL_WORD_FIRST_EN
           critical_word_valid,
`endif
           fill_done
  );

  modport slave (
    output miss_detected, miss_address, way0_meta, way1_meta,
           memory_data, memory_data_valid,
    input  fsm_busy, memory_enable, memory_address, write_data_array,
           data_way_sel, word_enable, set_enable, data_out, meta_wen,
           meta_way0_in, meta_way1_in,
`ifdef FILL_CRITICAL_WORD_FIRST_EN
           critical_word_valid,
`endif
           fill_done
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Miss-handling controller for a 2-way, 64-set cache with 8-word blocks.
// On a miss: picks the victim way, streams the block from pipelined memory
// into the data array, then writes both ways' metadata {tag, valid, lru}.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - cache_fill_if.master (miss request, metadata, memory request/return,
//          data/metadata array write controls, fill_done)
// Option: FILL_CRITICAL_WORD_FIRST_EN starts the block at the missed word and
// adds bus.critical_word_valid.
module cache_fill_fsm (
  input logic          clk,
  input logic          rst,
  cache_fill_if.master bus
);
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned WORD_W = 3;
  localparam int unsigned WORDS  = 8;
  localparam int unsigned SETS   = 64;
  localparam int unsigned META_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    TAG_WR = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [TAG_W-1:0]   tag_q, tag_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic [META_W-1:0]  meta0_q, meta0_nxt;
  logic [META_W-1:0]  meta1_q, meta1_nxt;
  logic               victim_q, victim_nxt;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_nxt;
  logic [WORD_W-1:0]  rcv_cnt_q, rcv_cnt_nxt;
  logic [WORD_W-1:0]  w_req, w_rcv;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
  logic [WORD_W-1:0]  off_q, off_nxt;
`endif

  // Victim choice: invalid way first, else the way marked LRU; a corrupt
  // (equal) LRU pair falls back to way0.
  function automatic logic pick_victim(input logic [META_W-1:0] m0,
                                       input logic [META_W-1:0] m1);
    if (!m0[1])         return 1'b0;
    if (!m1[1])         return 1'b1;
    if (m0[0] == m1[0]) return 1'b0;
    return m1[0];
  endfunction

  // Word order within the block; the 3-bit add wraps past word 7.
`ifdef FILL_CRITICAL_WORD_FIRST_EN
  assign w_req = off_q + WORD_W'(req_cnt_q);
  assign w_rcv = off_q + rcv_cnt_q;
`else
  assign w_req = WORD_W'(req_cnt_q);
  assign w_rcv = rcv_cnt_q;
`endif

  // State, latched miss context and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tag_q     <= '0;
      idx_q     <= '0;
      meta0_q   <= '0;
      meta1_q   <= '0;
      victim_q  <= 1'b0;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
      off_q     <= '0;
`endif
    end else begin
      state     <= state_nxt;
      tag_q     <= tag_nxt;
      idx_q     <= idx_nxt;
      meta0_q   <= meta0_nxt;
      meta1_q   <= meta1_nxt;
      victim_q  <= victim_nxt;
      req_cnt_q <= req_cnt_nxt;
      rcv_cnt_q <= rcv_cnt_nxt;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
      off_q     <= off_nxt;
`endif
    end
  end

  // Next state and output decode.
  always_comb begin
    state_nxt   = state;
    tag_nxt     = tag_q;
    idx_nxt     = idx_q;
    meta0_nxt   = meta0_q;
    meta1_nxt   = meta1_q;
    victim_nxt  = victim_q;
    req_cnt_nxt = req_cnt_q;
    rcv_cnt_nxt = rcv_cnt_q;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    off_nxt     = off_q;
    bus.critical_word_valid = 1'b0;
`endif
    bus.fsm_busy         = 1'b0;
    bus.memory_enable    = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.data_way_sel     = 1'b0;
    bus.word_enable      = '0;
    bus.set_enable       = '0;
    bus.data_out         = '0;
    bus.meta_wen         = 2'b00;
    bus.meta_way0_in     = '0;
    bus.meta_way1_in     = '0;
    bus.fill_done        = 1'b0;

    case (state)
      IDLE: begin
        if (bus.miss_detected) begin
          tag_nxt     = bus.miss_address[15:10];
          idx_nxt     = bus.miss_address[9:4];
          meta0_nxt   = bus.way0_meta;
          meta1_nxt   = bus.way1_meta;
          victim_nxt  = pick_victim(bus.way0_meta, bus.way1_meta);
          req_cnt_nxt = '0;
          rcv_cnt_nxt = '0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
          off_nxt     = bus.miss_address[3:1];
`endif
          state_nxt   = FILL;
        end
      end

      FILL: begin
        bus.fsm_busy     = 1'b1;
        bus.data_way_sel = victim_q;
        bus.set_enable   = SETS'(1) << idx_q;
        if (req_cnt_q < CNT_W'(WORDS)) begin
          bus.memory_enable  = 1'b1;
          bus.memory_address = {tag_q, idx_q, w_req, 1'b0};
          req_cnt_nxt        = req_cnt_q + CNT_W'(1);
        end
        // Returns are counted independently of requests, so they may overlap.
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          bus.word_enable      = WORDS'(1) << w_rcv;
          bus.data_out         = DATA_W'(bus.memory_data);
          rcv_cnt_nxt          = rcv_cnt_q + WORD_W'(1);
`ifdef FILL_CRITICAL_WORD_FIRST_EN
          bus.critical_word_valid = (rcv_cnt_q == '0);
`endif
          if (rcv_cnt_q == WORD_W'(WORDS - 1)) begin
            state_nxt = TAG_WR;
          end
        end
      end

      TAG_WR: begin
        bus.fsm_busy     = 1'b1;
        bus.data_way_sel = victim_q;
        bus.set_enable   = SETS'(1) << idx_q;
        bus.meta_wen     = 2'b11;
        bus.fill_done    = 1'b1;
        // Victim gets the new tag as most recent; the other way becomes LRU.
        if (victim_q) begin
          bus.meta_way1_in = {tag_q, 2'b10};
          bus.meta_way0_in = {meta0_q[META_W-1:1], 1'b1};
        end else begin
          bus.meta_way0_in = {tag_q, 2'b10};
          bus.meta_way1_in = {meta1_q[META_W-1:1], 1'b1};
        end
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: per-cycle vector tables for two complete
// fills, plus hand sequences for valid gaps, held miss, mid-fill reset and
// victim selection corner cases.
module tb_cache_fill_fsm;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  cache_fill_if bus ();

  cache_fill_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        miss;
    logic [15:0] addr;
    logic [7:0]  m0, m1;
    logic        valid;
    logic [15:0] mdata;
    logic        busy, men;
    logic [15:0] maddr;
    logic        wda, sel;
    logic [7:0]  wen;
    logic [63:0] set_en;
    logic [1:0]  mwen;
    logic [7:0]  mw0, mw1;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  function automatic int unsigned wo(input int unsigned k, input int unsigned off);
    return CWF ? (k + off) % 8 : k;
  endfunction

  function automatic vec_t blank();
    vec_t v;
    v.miss = 0; v.addr = '0; v.m0 = '0; v.m1 = '0; v.valid = 0; v.mdata = '0;
    v.busy = 0; v.men = 0; v.maddr = '0; v.wda = 0; v.sel = 0; v.wen = '0;
    v.set_en = '0; v.mwen = '0; v.mw0 = '0; v.mw1 = '0; v.done = 0;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic miss, input logic valid, input logic [15:0] d);
    bus.miss_detected     = miss;
    bus.memory_data_valid = valid;
    bus.memory_data       = d;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string name, input int i, input vec_t e);
    chk({name, "_busy"}, i, 64'(bus.fsm_busy), 64'(e.busy));
    chk({name, "_men"},  i, 64'(bus.memory_enable), 64'(e.men));
    if (e.men || !e.busy) chk({name, "_maddr"}, i, 64'(bus.memory_address), 64'(e.maddr));
    chk({name, "_wda"},  i, 64'(bus.write_data_array), 64'(e.wda));
    chk({name, "_sel"},  i, 64'(bus.data_way_sel), 64'(e.sel));
    chk({name, "_wen"},  i, 64'(bus.word_enable), 64'(e.wen));
    chk({name, "_set"},  i, bus.set_enable, e.set_en);
    chk({name, "_mwen"}, i, 64'(bus.meta_wen), 64'(e.mwen));
    if (e.mwen != 0 || !e.busy) begin
      chk({name, "_mw0"}, i, 64'(bus.meta_way0_in), 64'(e.mw0));
      chk({name, "_mw1"}, i, 64'(bus.meta_way1_in), 64'(e.mw1));
    end
    chk({name, "_done"}, i, 64'(bus.fill_done), 64'(e.done));
    chk({name, "_dout"}, i, 64'(bus.data_out), e.wda ? 64'(e.mdata) : 64'(0));
  endtask

  vec_t v;
  logic vld;
  int   k, reqs, dones, mwen_seen;
  logic [7:0] vm0 [4];
  logic [7:0] vm1 [4];
  logic       vexp [4];

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b0;
    bus.miss_detected = 0; bus.miss_address = '0; bus.way0_meta = '0;
    bus.way1_meta = '0; bus.memory_data = '0; bus.memory_data_valid = 0;

    // Table 1: cold miss 0x1A36, 4-cycle memory, metadata inputs garbled after latch.
    v = blank(); v.miss = 1; v.addr = 16'h1A36; v.m0 = 8'h00; v.m1 = 8'h44;
    vecs.push_back(v);
    for (int c = 1; c <= 13; c++) begin
      v = blank(); v.addr = 16'h1A36; v.m0 = 8'hFF; v.m1 = 8'hFF;
      v.busy = 1; v.sel = 0; v.set_en = 64'(1) << 35;
      if (c <= 8) begin v.men = 1; v.maddr = 16'h1A30 + 16'(2 * wo(c - 1, 3)); end
      if (c >= 5 && c <= 12) begin
        v.valid = 1; v.mdata = 16'hA000 + 16'(c); v.wda = 1; v.wen = 8'(1) << wo(c - 5, 3);
      end
      if (c == 13) begin v.mwen = 2'b11; v.mw0 = 8'h1A; v.mw1 = 8'h45; v.done = 1; end
      vecs.push_back(v);
    end
    vecs.push_back(blank());
    // Table 2: both valid, way1 LRU -> victim way1; 1-cycle memory; valid in IDLE ignored.
    v = blank(); v.miss = 1; v.addr = 16'hFC84; v.m0 = 8'h46; v.m1 = 8'h8B;
    vecs.push_back(v);
    for (int c = 1; c <= 10; c++) begin
      v = blank(); v.addr = 16'hFC84; v.m0 = 8'h00; v.m1 = 8'h00;
      v.busy = 1; v.sel = 1; v.set_en = 64'(1) << 8;
      if (c <= 8) begin v.men = 1; v.maddr = 16'hFC80 + 16'(2 * wo(c - 1, 2)); end
      if (c >= 2 && c <= 9) begin
        v.valid = 1; v.mdata = 16'h5A00 + 16'(c * 3); v.wda = 1; v.wen = 8'(1) << wo(c - 2, 2);
      end
      if (c == 10) begin v.mwen = 2'b11; v.mw0 = 8'h47; v.mw1 = 8'hFE; v.done = 1; end
      vecs.push_back(v);
    end
    v = blank(); v.valid = 1; v.mdata = 16'hABCD;
    vecs.push_back(v);

    // Reset state.
    step(); step();
    drive(0, 0, 16'h0);
    check_vec("reset", 0, blank());
    step();
    rst = 1'b1;

    foreach (vecs[i]) begin
      bus.miss_address = vecs[i].addr;
      bus.way0_meta    = vecs[i].m0;
      bus.way1_meta    = vecs[i].m1;
      drive(vecs[i].miss, vecs[i].valid, vecs[i].mdata);
      check_vec("vec", i, vecs[i]);
      step();
    end

    // Gapped valids: TAG_WR exactly one cycle after the 8th valid.
    bus.miss_address = 16'h0000; bus.way0_meta = 8'h02; bus.way1_meta = 8'h00;
    k = 0;
    for (int c = 0; c <= 18; c++) begin
      vld = (c == 5 || c == 6 || c == 9 || c == 10 || c == 11 || c == 14 || c == 15 || c == 16);
      drive(c == 0, vld, 16'hB000 + 16'(c));
      chk("gap_busy", c, 64'(bus.fsm_busy), 64'(c >= 1 && c <= 17));
      chk("gap_done", c, 64'(bus.fill_done), 64'(c == 17));
      chk("gap_wda", c, 64'(bus.write_data_array), 64'(vld));
      if (vld) begin
        chk("gap_wen", c, 64'(bus.word_enable), 64'(8'(1) << wo(k, 0)));
        k++;
      end
      if (c == 17) begin
        chk("gap_mwen", c, 64'(bus.meta_wen), 64'(2'b11));
        chk("gap_mw0", c, 64'(bus.meta_way0_in), 64'(8'h03));
        chk("gap_mw1", c, 64'(bus.meta_way1_in), 64'(8'h02));
      end
      step();
    end

    // Miss held high through a fill: one fill, next one only after IDLE.
    bus.miss_address = 16'h2468; bus.way0_meta = 8'h00; bus.way1_meta = 8'h00;
    reqs = 0; dones = 0;
    for (int c = 0; c <= 14; c++) begin
      drive(1, c >= 5 && c <= 12, 16'h1100 + 16'(c));
      if (bus.memory_enable) reqs++;
      if (bus.fill_done) dones++;
      if (c == 14) chk("hold_idle_busy", c, 64'(bus.fsm_busy), 64'(0));
      step();
    end
    chk("hold_reqs", 0, 64'(reqs), 64'(8));
    chk("hold_dones", 0, 64'(dones), 64'(1));
    dones = 0;
    for (int c = 15; c <= 26; c++) begin
      drive(0, c >= 16 && c <= 23, 16'h2200 + 16'(c));
      if (c == 15) begin
        chk("hold2_busy", c, 64'(bus.fsm_busy), 64'(1));
        chk("hold2_maddr", c, 64'(bus.memory_address), 64'(16'h2460 + 16'(2 * wo(0, 4))));
      end
      if (c == 24) chk("hold2_done", c, 64'(bus.fill_done), 64'(1));
      if (bus.fill_done) dones++;
      step();
    end
    chk("hold2_dones", 0, 64'(dones), 64'(1));

    // Reset at the 4th data word, then a fresh miss completes.
    bus.miss_address = 16'h1A36; bus.way0_meta = 8'h00; bus.way1_meta = 8'h00;
    mwen_seen = 0;
    for (int c = 0; c <= 9; c++) begin
      rst = (c == 8) ? 1'b0 : 1'b1;
      drive(c == 0, c >= 5 && c <= 9, 16'h3300 + 16'(c));
      if (bus.meta_wen != 2'b00) mwen_seen++;
      if (c == 9) check_vec("rst_after", c, blank());
      step();
    end
    chk("rst_no_mwen", 0, 64'(mwen_seen), 64'(0));
    bus.way0_meta = 8'h1A; bus.way1_meta = 8'h47;
    for (int c = 10; c <= 21; c++) begin
      drive(c == 10, c >= 12 && c <= 19, 16'h4400 + 16'(c));
      if (c == 11) chk("rst2_maddr", c, 64'(bus.memory_address), 64'(16'h1A30 + 16'(2 * wo(0, 3))));
      if (c == 12) chk("rst2_wen", c, 64'(bus.word_enable), 64'(8'(1) << wo(0, 3)));
      if (c == 20) begin
        chk("rst2_done", c, 64'(bus.fill_done), 64'(1));
        chk("rst2_mw0", c, 64'(bus.meta_way0_in), 64'(8'h1B));
        chk("rst2_mw1", c, 64'(bus.meta_way1_in), 64'(8'h1A));
      end
      if (c == 21) chk("rst2_idle", c, 64'(bus.fsm_busy), 64'(0));
      step();
    end

    // Victim selection corners, each fill aborted by reset.
    vm0[0] = 8'h03; vm1[0] = 8'h03; vexp[0] = 1'b0;
    vm0[1] = 8'h03; vm1[1] = 8'h02; vexp[1] = 1'b0;
    vm0[2] = 8'h02; vm1[2] = 8'h03; vexp[2] = 1'b1;
    vm0[3] = 8'h02; vm1[3] = 8'h00; vexp[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.way0_meta = vm0[i]; bus.way1_meta = vm1[i];
      drive(1, 0, 16'h0);
      step();
      drive(0, 0, 16'h0);
      chk("victim_sel", i, 64'(bus.data_way_sel), 64'(vexp[i]));
      step();
      rst = 1'b0;
      drive(0, 0, 16'h0);
      step();
      rst = 1'b1;
    end

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    // Critical word first from offset 6.
    bus.miss_address = 16'h000C; bus.way0_meta = 8'h00; bus.way1_meta = 8'h00;
    for (int c = 0; c <= 14; c++) begin
      drive(c == 0, c >= 5 && c <= 12, 16'h6600 + 16'(c));
      if (c == 1) chk("cwf_maddr", c, 64'(bus.memory_address), 64'(16'h000C));
      if (c == 3) chk("cwf_wrap", c, 64'(bus.memory_address), 64'(16'h0000));
      if (c == 5) chk("cwf_wen", c, 64'(bus.word_enable), 64'(8'h40));
      if (c >= 5 && c <= 6) chk("cwf_crit", c, 64'(bus.critical_word_valid), 64'(c == 5));
      step();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller for one 2-way, 64-set cache: 16-bit address, 16-byte blocks of eight 16-bit words. On a miss it picks the victim way, streams the block from pipelined main memory into the data array, then writes both ways' metadata words (6-bit tag, valid, LRU) for the indexed set. It sits between the hit/miss compare logic and the data and metadata way arrays, and it drives those arrays' write ports during a fill.

## Interface
- Parameters: none. Geometry is fixed.
  - Address split: tag = addr[15:10], index = addr[9:4], word = addr[3:1], addr[0] = byte.
  - Metadata word = {tag[5:0], valid, LRU}.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. Synchronous, active-low: sampled 0 on a clk edge resets the block.
- miss_detected  in  1  miss request, sampled only in IDLE.
- miss_address  in  16  address that missed.
- way0_meta, way1_meta  in  8 each  current metadata of the indexed set, read from way0 / way1.
- memory_data  in  16  returned memory word.
- memory_data_valid  in  1  memory_data is valid this cycle.
- fsm_busy  out  1  high in FILL and TAG_WR.
- memory_enable  out  1  read request to memory this cycle.
- memory_address  out  16  request address, always word-aligned.
- write_data_array  out  1  write memory_data into the data array.
- data_way_sel  out  1  victim way (0/1).
- word_enable  out  8  one-hot word select within the block.
- set_enable  out  64  one-hot decode of the latched index; shared by the data and metadata arrays.
- data_out  out  16  equals memory_data (combinational).
- meta_wen  out  2  per-way metadata write enable.
- meta_way0_in, meta_way1_in  out  8 each  metadata words to write.
- fill_done  out  1  one-cycle pulse in TAG_WR.

## Operation
- States: IDLE, FILL, TAG_WR.
- IDLE
  - All outputs are 0.
  - On miss_detected=1: latch tag, index, word offset, way0_meta and way1_meta; compute the victim; clear req_cnt and rcv_cnt; go to FILL.
- Victim selection, from latched metadata:
  - way0 valid=0 -> way0.
  - else way1 valid=0 -> way1.
  - else the way whose LRU bit is 1.
  - If both LRU bits are equal (corrupt state) -> way0.
- FILL
  - While req_cnt<8: memory_enable=1, memory_address={tag,index,w_req,1'b0}, req_cnt++.
  - Each cycle memory_data_valid=1: write_data_array=1, word_enable=onehot(w_rcv), rcv_cnt++.
  - When the 8th word is received (rcv_cnt==7 with valid), go to TAG_WR.
  - Requests and receives overlap. A word received in the same cycle as a request is legal.
- TAG_WR (one cycle)
  - meta_wen=2'b11 and fill_done=1.
  - Victim way's word = {tag,1,0}.
  - Other way's word = its latched metadata with bit0 forced to 1.
  - Next state: IDLE.
- Word order: w_req = req_cnt, w_rcv = rcv_cnt (3-bit).
- set_enable holds its one-hot value through FILL and TAG_WR.
- Ignored inputs:
  - miss_detected while busy is ignored; there is no queuing.
  - memory_data_valid outside FILL is ignored.
  - Valid pulses beyond 8 cannot occur, because the block exits FILL on the 8th.
- Reset at any point, including mid-fill, gives IDLE next cycle with counters 0 and all outputs 0.
  - No partial metadata write occurs. The data array may hold partial words, but the tag stays unwritten, so those words never hit.

## Timing
- Miss sampled at edge N: FILL from N+1, requests in cycles N+1..N+8.
- With the codebase's 4-cycle memory: data in cycles N+5..N+12, TAG_WR at N+13, IDLE at N+14. A new miss is accepted at N+14.
- Completion is count-driven, not latency-driven, so any memory latency ≥1 works. Stalled valids extend FILL.
- All state and counters are registered. Outputs are decoded from state and counters; data_out, write_data_array and word_enable also follow memory_data_valid combinationally.

## Configuration
- FILL_CRITICAL_WORD_FIRST_EN defined:
  - w_req = (offset+req_cnt) mod 8 and w_rcv = (offset+rcv_cnt) mod 8, wrapping past word 7 to 0.
  - Extra output critical_word_valid (1 bit) pulses with the first received word (rcv_cnt==0).
- Undefined: order is 0..7 and the port is absent.

## Test plan
- Cold miss, addr 0x1A36, both ways invalid.
  - Requests 0x1A30..0x1A3E in order; 8 data writes to way0, set_enable[35]=1.
  - TAG_WR: way0 gets {6'h06,1,0}; way1 gets its old word with bit0=1; fill_done 1 cycle.
  - Busy for 13 cycles.
- Both ways valid, way1 LRU=1, way0 LRU=0 -> victim way1; way0 LRU becomes 1.
- Gaps in memory_data_valid (valids at cycles 5,6,9,10,11,14,15,16) -> TAG_WR exactly one cycle after the 8th valid; word_enable order unchanged.
- miss_detected held high through a fill -> exactly one fill; second fill starts only after return to IDLE.
- rst=0 at the 4th data word -> next cycle all outputs 0, meta_wen never asserted; a fresh miss then completes normally.
- With FILL_CRITICAL_WORD_FIRST_EN, addr 0x000C (offset 6) -> request words 6,7,0,1..5; critical_word_valid on the first return, with word_enable=8'h40.
